irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Prioritised interrupt controller for the RISC5 CPU. It gathers up to `num_irq` synchronous interrupt sources into pending/enable registers and drives the CPU's single edge-sensitive `irq` input. It uses the CPU's `intAck` and `RTI` strobes to track which source is being serviced, and exposes its registers on the IO bus.

## Interface
- `num_irq`, default 8, is the number of sources, in the range 1..32.
- `clk`  in  1  is the system clock. All state changes on its rising edge.
- `rst`  in  1  is an asynchronous, active-high reset.
- `en`  in  1  qualifies all state updates. Connect it to `~wait_req`; while it is low, every register holds.
- `irq_in`  in  `num_irq`  carries the interrupt sources, synchronous to `clk`. Each rising edge is one event.
- `int_ack`  in  1  is the CPU `intackx` strobe.
- `rti`  in  1  is the CPU `rtix` strobe.
- `irq`  out  1  drives the CPU `irq` input. It is registered.
- `io_en`  in  1  selects this device for the current bus cycle.
- `io_wr`  in  1  marks the cycle as a write; otherwise it is a read.
- `io_adr`  in  2  is the register select.
- `io_din`  in  32  is the write data.
- `io_dout`  out  32  is the read data.

## Operation
- State registers:
  - `pend` (`num_irq` bits)
  - `enb` (`num_irq` bits)
  - `src_d` (`num_irq` bits, the previous `irq_in`)
  - `busy` (1 bit)
  - `cur` (5 bits, the number of the source in service)
  - `irq` (1 bit)
- Reset clears every register above to 0, including `irq`.
- **Edge detection.** `new = irq_in & ~src_d`. `src_d <= irq_in` on every enabled cycle.
- **Winner.** `win` is the lowest index `i` with `pend[i] & enb[i]`. `act` is true if any such `i` exists. This logic is combinational.
- **`irq` register.** On an enabled cycle, `irq <= act & ~busy & ~(int_ack | rti)`.
  - `irq` is low for the whole service interval.
  - Because of this, every new request produces a fresh rising edge for the CPU's edge detector.
- **Acknowledge.** When `int_ack & en`:
  - `cur <= win`.
  - `busy <= 1`.
  - `pend[win]` is cleared.
  - If `act` is 0 (a spurious ack), `cur <= 31`, `busy` is still set, and no pending bit changes.
- **Return.** When `rti & en & busy`, `busy <= 0`.
  - `rti` while not busy is ignored.
  - If `int_ack` and `rti` are both high in the same cycle, `int_ack` wins.
- **Pending update, per bit.**
  - `pend <= (pend & ~w1c & ~ackclr) | new | w1s`.
  - A set always beats a clear in the same cycle. This includes an ack and a new edge on the same bit together: the bit stays pending.
- **IO registers.** A write takes effect when `io_en & io_wr & en`. Reads are combinational: `io_dout` is 0 when `io_en` is 0. Bits at and above `num_irq` read 0 and ignore writes.
  - `adr 0`: reads `pend`. A write clears the bits written as 1 (`w1c`).
  - `adr 1`: reads and writes `enb`.
  - `adr 2`: reads `{busy, 23'b0, 3'b0, cur}`. A write sets the pending bits written as 1 (`w1s`, software trigger).
  - `adr 3`: reads `{act, 26'b0, win}`. A write of any value forces `busy <= 0`. This is the software recovery path after an aborted handler.
- Disabling a source (`enb` bit to 0) keeps its pending bit; it is serviced when it is re-enabled.

## Timing
- A source edge seen at clock edge k sets `pend` at edge k. `irq` rises at edge k+1, provided the controller is not busy.
- The CPU registers `irq` one cycle later. It asserts `int_ack` combinationally when it is not stalled. `irq` falls at the edge that samples `int_ack`.
- After `rti` at edge r, `irq` is low at r and may rise at r+1 if `act`. This gives at least one low cycle between requests.
- While `en` is 0, all registers hold, and `int_ack` and `rti` are not consumed. A CPU strobe held over several stalled cycles therefore counts exactly once.
- An asynchronous `rst` mid-service immediately clears `busy`, `pend`, `enb`, and drops `irq` low.

## Test plan
- **Basic service.** Reset, write `enb` to 0x05, pulse `irq_in[2]`.
  - `irq` rises 1 cycle after `pend[2]` is set.
  - An `int_ack` pulse gives `cur` = 2, `busy` = 1, `pend` = 0, and `irq` low.
  - An `rti` pulse gives `busy` = 0.
- **Priority.** Pulse `irq_in[0]` and `irq_in[2]` together with `enb` = 0x05.
  - The first ack gives `cur` = 0. `irq` stays low until `rti`, then re-rises one cycle later.
  - The second ack gives `cur` = 2.
- **Masking.** With `enb` = 0, pulse `irq_in[1]`.
  - `pend` = 0x02 and `irq` stays 0.
  - Writing `enb` = 0x02 makes `irq` go to 1 on the next cycle.
  - A `w1c` write of 0x02 to adr 0 before the ack drops `irq` the following cycle.
- **Simultaneous set/clear.** In the same cycle, do an ack of source 3 and a new `irq_in[3]` edge.
  - `pend[3]` remains 1.
  - A `w1c` write to adr 0 concurrent with a new edge also leaves the bit at 1.
- **Stall.** Hold `en` = 0 for 4 cycles with `int_ack` high.
  - No state changes during the stall.
  - When `en` returns, exactly one ack is taken: one pending bit is cleared.
- **Reset and recovery.**
  - Assert `rst` while `busy` = 1 and `pend` = 0xFF: all registers and `irq` read 0 immediately.
  - Separately, a write to adr 3 while busy clears `busy`, and adr 2 reads 0x0000000k.

Source files
------------

// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller for the RISC5 CPU: edge-detected sources,
// pending/enable registers, lowest-index-wins arbitration and IO bus access.
module irq_ctrl #(
   parameter int num_irq = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [num_irq-1:0] irq_in,
   input  logic               int_ack,
   input  logic               rti,
   output logic               irq,
   input  logic               io_en,
   input  logic               io_wr,
   input  logic [1:0]         io_adr,
   input  logic [31:0]        io_din,
   output logic [31:0]        io_dout
);

   logic [num_irq-1:0] pend;
   logic [num_irq-1:0] enb;
   logic [num_irq-1:0] src_d;
   logic               busy;
   logic [4:0]         cur;

   logic [num_irq-1:0] new_edge;
   logic [num_irq-1:0] w1c;
   logic [num_irq-1:0] w1s;
   logic [num_irq-1:0] ack_clr;
   logic [4:0]         win;
   logic               act;
   logic               ack;
   logic               wr;
   logic               wr_enb;
   logic               wr_rec;
   logic [31:0]        rd;
   logic               unused_din;

   assign unused_din = ^io_din;

   assign new_edge = irq_in & ~src_d;
   assign ack      = int_ack & en;
   assign wr       = io_en & io_wr & en;
   assign w1c      = (wr && io_adr == 2'd0) ? io_din[num_irq-1:0] : '0;
   assign wr_enb   =  wr && io_adr == 2'd1;
   assign w1s      = (wr && io_adr == 2'd2) ? io_din[num_irq-1:0] : '0;
   assign wr_rec   =  wr && io_adr == 2'd3;

   // Scan from the top so the lowest requesting index is the last one kept.
   always_comb begin
      win = '0;
      act = 1'b0;
      for (int i = num_irq - 1; i >= 0; i--) begin
         if (pend[i] && enb[i]) begin
            win = 5'(i);
            act = 1'b1;
         end
      end
   end

   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < num_irq; i++) begin
         ack_clr[i] = ack & act & (win == 5'(i));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend  <= '0;
         enb   <= '0;
         src_d <= '0;
         busy  <= 1'b0;
         cur   <= '0;
         irq   <= 1'b0;
      end else if (en) begin
         src_d <= irq_in;
         // Sets are or-ed in last so they beat any clear on the same bit.
         pend  <= (pend & ~w1c & ~ack_clr) | new_edge | w1s;
         irq   <= act & ~busy & ~(int_ack | rti);
         if (wr_enb) begin
            enb <= io_din[num_irq-1:0];
         end
         if (int_ack) begin
            busy <= 1'b1;
            cur  <= act ? win : 5'd31;
         end else if ((rti && busy) || wr_rec) begin
            busy <= 1'b0;
         end
      end
   end

   always_comb begin
      rd = '0;
      case (io_adr)
         2'd0:    rd[num_irq-1:0] = pend;
         2'd1:    rd[num_irq-1:0] = enb;
         2'd2:    rd = {busy, 26'b0, cur};
         default: rd = {act, 26'b0, win};
      endcase
      io_dout = io_en ? rd : 32'd0;
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_irq_ctrl;
   localparam int NI = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [NI-1:0] irq_in;
   logic          int_ack;
   logic          rti;
   logic          irq;
   logic          io_en;
   logic          io_wr;
   logic [1:0]    io_adr;
   logic [31:0]   io_din;
   logic [31:0]   io_dout;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   irq_ctrl #(.num_irq(NI)) dut (
      .clk(clk), .rst(rst), .en(en), .irq_in(irq_in), .int_ack(int_ack),
      .rti(rti), .irq(irq), .io_en(io_en), .io_wr(io_wr), .io_adr(io_adr),
      .io_din(io_din), .io_dout(io_dout)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   logic [NI-1:0] m_pend, m_enb, m_src;
   logic          m_busy, m_irq;
   logic [4:0]    m_cur;

   function automatic int lowest(input logic [NI-1:0] p, input logic [NI-1:0] e);
      for (int i = 0; i < NI; i++)
         if (p[i] && e[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] exp_dout();
      int w;
      w = lowest(m_pend, m_enb);
      if (!io_en) return 32'd0;
      case (io_adr)
         2'd0:    return {24'd0, m_pend};
         2'd1:    return {24'd0, m_enb};
         2'd2:    return (m_busy ? 32'h8000_0000 : 32'd0) + {27'd0, m_cur};
         default: return (w >= 0) ? (32'h8000_0000 + 32'(w)) : 32'd0;
      endcase
   endfunction

   int            mw;
   logic [NI-1:0] np;
   logic          do_wr;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pend <= '0; m_enb <= '0; m_src <= '0;
         m_busy <= 1'b0; m_irq <= 1'b0; m_cur <= '0;
      end else if (en) begin
         mw    = lowest(m_pend, m_enb);
         do_wr = io_en && io_wr;
         for (int i = 0; i < NI; i++) begin
            if ((irq_in[i] && !m_src[i]) || (do_wr && io_adr == 2'd2 && io_din[i]))
               np[i] = 1'b1;
            else if ((do_wr && io_adr == 2'd0 && io_din[i]) || (int_ack && mw == i))
               np[i] = 1'b0;
            else
               np[i] = m_pend[i];
         end
         m_pend <= np;
         m_src  <= irq_in;
         m_irq  <= (mw >= 0) && !m_busy && !int_ack && !rti;
         if (do_wr && io_adr == 2'd1) m_enb <= io_din[NI-1:0];
         if (int_ack) begin
            m_busy <= 1'b1;
            m_cur  <= (mw >= 0) ? 5'(mw) : 5'd31;
         end else if (rti || (do_wr && io_adr == 2'd3)) begin
            m_busy <= 1'b0;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_on) begin
         checks++;
         if (irq !== m_irq) begin
            errors++;
            $display("FAIL model_irq t=%0t got=%b exp=%b", $time, irq, m_irq);
         end
         checks++;
         if (io_dout !== exp_dout()) begin
            errors++;
            $display("FAIL model_dout t=%0t adr=%0d got=%h exp=%h", $time, io_adr, io_dout, exp_dout());
         end
      end
   end

   task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
      io_en = 1'b1; io_wr = 1'b0; io_adr = a;
      #1;
      lit(name, io_dout, exp);
      io_en = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      io_en = 1'b1; io_wr = 1'b1; io_adr = a; io_din = d;
      cyc();
      io_en = 1'b0; io_wr = 1'b0; io_din = '0;
   endtask

   task automatic pulse_ack();
      int_ack = 1'b1; cyc(); int_ack = 1'b0;
   endtask

   task automatic pulse_rti();
      rti = 1'b1; cyc(); rti = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; irq_in = '0; int_ack = 1'b0; rti = 1'b0;
      io_en = 1'b0; io_wr = 1'b0; io_adr = '0; io_din = '0;
      cyc();
      chk_on = 1'b1;
      cyc();
      rst = 1'b0;
      lit("reset_irq", {31'd0, irq}, 32'd0);
      rd(2'd0, 32'd0, "reset_pend");
      rd(2'd2, 32'd0, "reset_stat");
      cyc();
      rd(2'd1, 32'd0, "reset_enb");
      rd(2'd3, 32'd0, "reset_win");

      // Basic service
      wr(2'd1, 32'h05);
      irq_in = 8'h04; cyc(); irq_in = '0;
      lit("basic_irq_k", {31'd0, irq}, 32'd0);
      rd(2'd0, 32'h04, "basic_pend");
      cyc();
      lit("basic_irq_k1", {31'd0, irq}, 32'd1);
      pulse_ack();
      lit("basic_irq_ack", {31'd0, irq}, 32'd0);
      rd(2'd2, 32'h8000_0002, "basic_cur");
      rd(2'd0, 32'd0, "basic_pend_clr");
      pulse_rti();
      rd(2'd2, 32'h0000_0002, "basic_rti");

      // Priority
      irq_in = 8'h05; cyc(); irq_in = '0; cyc();
      lit("prio_irq", {31'd0, irq}, 32'd1);
      pulse_ack();
      rd(2'd2, 32'h8000_0000, "prio_cur0");
      cyc();
      lit("prio_low_busy", {31'd0, irq}, 32'd0);
      pulse_rti();
      lit("prio_low_r", {31'd0, irq}, 32'd0);
      cyc();
      lit("prio_rerise", {31'd0, irq}, 32'd1);
      pulse_ack();
      rd(2'd2, 32'h8000_0002, "prio_cur2");
      pulse_rti();

      // Masking
      wr(2'd1, 32'h00);
      irq_in = 8'h02; cyc(); irq_in = '0; cyc();
      rd(2'd0, 32'h02, "mask_pend");
      lit("mask_irq0", {31'd0, irq}, 32'd0);
      wr(2'd1, 32'h02);
      cyc();
      lit("mask_irq1", {31'd0, irq}, 32'd1);
      wr(2'd0, 32'h02);
      cyc();
      lit("mask_w1c_drop", {31'd0, irq}, 32'd0);

      // Simultaneous set/clear
      wr(2'd1, 32'h08);
      irq_in = 8'h08; cyc(); irq_in = '0; cyc();
      lit("sim_irq", {31'd0, irq}, 32'd1);
      int_ack = 1'b1; irq_in = 8'h08; cyc(); int_ack = 1'b0; irq_in = '0;
      rd(2'd0, 32'h08, "sim_ack_edge");
      rd(2'd2, 32'h8000_0003, "sim_cur3");
      pulse_rti();
      irq_in = 8'h08; wr(2'd0, 32'h08); irq_in = '0;
      rd(2'd0, 32'h08, "sim_w1c_edge");
      wr(2'd0, 32'h08);

      // Stall
      wr(2'd1, 32'hFF);
      wr(2'd2, 32'hFF);
      cyc();
      lit("stall_irq", {31'd0, irq}, 32'd1);
      en = 1'b0; int_ack = 1'b1;
      repeat (4) cyc();
      rd(2'd0, 32'hFF, "stall_pend_hold");
      rd(2'd2, 32'h0000_0003, "stall_stat_hold");
      en = 1'b1; cyc(); int_ack = 1'b0;
      rd(2'd0, 32'hFE, "stall_one_ack");
      rd(2'd2, 32'h8000_0000, "stall_cur");

      // Recovery and reset mid-service
      wr(2'd3, 32'h0);
      rd(2'd2, 32'h0000_0000, "recover_stat");
      pulse_ack();
      wr(2'd2, 32'hFF);
      rd(2'd0, 32'hFF, "pre_rst_pend");
      rst = 1'b1;
      #1;
      lit("rst_irq", {31'd0, irq}, 32'd0);
      rd(2'd0, 32'd0, "rst_pend");
      rd(2'd2, 32'd0, "rst_stat");
      cyc();
      rd(2'd1, 32'd0, "rst_enb");
      rst = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         irq_in  = irq_in ^ 8'($urandom & $urandom & $urandom);
         en      = ($urandom_range(0, 7) != 0);
         int_ack = ($urandom_range(0, 9) == 0);
         rti     = ($urandom_range(0, 7) == 0);
         io_en   = ($urandom_range(0, 3) == 0);
         io_wr   = ($urandom_range(0, 2) == 0);
         io_adr  = 2'($urandom);
         io_din  = $urandom;
         rst     = ($urandom_range(0, 499) == 0);
         cyc();
      end
      rst = 1'b0; io_en = 1'b0; int_ack = 1'b0; rti = 1'b0;
      cyc();
      chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
